// File: rtl/nic_fifo.sv
// rtl/nic_fifo.sv - NIC between a PE and its router, with input/output packet FIFOs
// Ring buffer shared by both directions; pointers wrap at DEPTH so non-power-of-two depths work.
module nic_fifo_ring #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] head,
   output logic [7:0]   count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [0:(1<<PW)-1];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)
            count <= count + 8'd1;
         else if (pop && !push)
            count <= count - 8'd1;
      end
   end

   // Contents need no reset: head is only consumed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign head = mem[rd_ptr];
endmodule

module nic_fifo #(
   parameter int DATA_W    = 64,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4,
   parameter int VC_BIT    = 63
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              nicEn,
   input  logic              nicWrEN,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di,
   input  logic              net_ro,
   input  logic              net_polarity,
   output logic              net_so,
   output logic [DATA_W-1:0] net_do
);
   logic              pe_rd, pe_wr;
   logic              in_push, in_pop, out_push, out_pop;
   logic [7:0]        in_count, out_count;
   logic [DATA_W-1:0] in_head, out_head;
   logic              in_empty, out_empty, out_full;
   logic              in_underflow, out_overflow;
   logic              uf_set, uf_clr, ov_set, ov_clr;

   assign pe_rd     = nicEn && !nicWrEN;
   assign pe_wr     = nicEn && nicWrEN;
   assign in_empty  = (in_count == 8'd0);
   assign out_empty = (out_count == 8'd0);
   assign out_full  = (out_count == 8'(OUT_DEPTH));
   assign net_ri    = (in_count != 8'(IN_DEPTH));

   assign in_push  = net_si && net_ri;
   assign in_pop   = pe_rd && (addr == 2'b00) && !in_empty;
   assign out_push = pe_wr && (addr == 2'b10) && !out_full;
   // A head on the wrong VC phase stalls the whole queue; there is no bypass.
   assign out_pop  = !out_empty && net_ro && (out_head[VC_BIT] == net_polarity);

   assign uf_set = pe_rd && (addr == 2'b00) && in_empty;
   assign uf_clr = pe_rd && (addr == 2'b01);
   assign ov_set = pe_wr && (addr == 2'b10) && out_full;
   assign ov_clr = pe_rd && (addr == 2'b11);

   nic_fifo_ring #(.DEPTH(IN_DEPTH), .W(DATA_W)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_push),
      .pop   (in_pop),
      .wdata (net_di),
      .head  (in_head),
      .count (in_count)
   );

   nic_fifo_ring #(.DEPTH(OUT_DEPTH), .W(DATA_W)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .pop   (out_pop),
      .wdata (d_in),
      .head  (out_head),
      .count (out_count)
   );

   // Set beats a same-cycle status-read clear so no error event is lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_underflow <= 1'b0;
         out_overflow <= 1'b0;
      end else begin
         in_underflow <= uf_set || (in_underflow && !uf_clr);
         out_overflow <= ov_set || (out_overflow && !ov_clr);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         net_so <= 1'b0;
         net_do <= '0;
      end else begin
         net_so <= out_pop;
         if (out_pop) net_do <= out_head;
      end
   end

   always_comb begin
      d_out = '0;
      if (pe_rd) begin
         case (addr)
            2'b00: if (!in_empty) d_out = in_head;
            2'b01: begin
               d_out[0]   = !in_empty;
               d_out[8:1] = in_count;
               d_out[9]   = in_underflow;
            end
            2'b11: begin
               d_out[0]   = out_full;
               d_out[8:1] = out_count;
               d_out[9]   = out_overflow;
            end
            default: d_out = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_nic_fifo.sv
// tb/tb_nic_fifo.sv - scoreboard bench for nic_fifo against a queue-based reference model
`timescale 1ns/1ps
module tb_nic_fifo;
   localparam int IN_D  = 3;
   localparam int OUT_D = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        nicEn = 1'b0, nicWrEN = 1'b0;
   logic [1:0]  addr = 2'b00;
   logic [63:0] d_in = '0, d_out;
   logic        net_si = 1'b0, net_ri;
   logic [63:0] net_di = '0;
   logic        net_ro = 1'b0, net_polarity = 1'b0, net_so;
   logic [63:0] net_do;

   nic_fifo #(.DATA_W(64), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D), .VC_BIT(63)) dut (
      .clk(clk), .reset(reset), .nicEn(nicEn), .nicWrEN(nicWrEN), .addr(addr),
      .d_in(d_in), .d_out(d_out), .net_si(net_si), .net_ri(net_ri), .net_di(net_di),
      .net_ro(net_ro), .net_polarity(net_polarity), .net_so(net_so), .net_do(net_do)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   logic [63:0] m_in[$];
   logic [63:0] m_out[$];
   bit          m_uf, m_ov;
   logic [63:0] exp_dout[$];
   logic        exp_ri[$];
   logic [63:0] exp_tx[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] status(input int cnt, input bit flag, input bit b0);
      logic [63:0] s;
      logic [7:0]  c;
      c = cnt[7:0];
      s = '0;
      s[0] = b0;
      s[8:1] = c;
      s[9] = flag;
      return s;
   endfunction

   // One clock of stimulus; expectations come from the model state as it stands before the edge.
   task automatic cycle(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                        input logic si, input logic [63:0] di, input logic ro, input logic pol);
      logic [63:0] e;
      bit in_can_push, out_can_push, inj;
      logic [63:0] inj_pkt;
      @(posedge clk);
      #1;
      nicEn = en; nicWrEN = wr; addr = a; d_in = din;
      net_si = si; net_di = di; net_ro = ro; net_polarity = pol;

      e = '0;
      if (en && !wr) begin
         case (a)
            2'b00: e = (m_in.size() != 0) ? m_in[0] : 64'd0;
            2'b01: e = status(m_in.size(), m_uf, m_in.size() != 0);
            2'b11: e = status(m_out.size(), m_ov, m_out.size() == OUT_D);
            default: e = '0;
         endcase
      end
      exp_dout.push_back(e);
      exp_ri.push_back(m_in.size() != IN_D);

      in_can_push  = si && (m_in.size() < IN_D);
      out_can_push = (m_out.size() < OUT_D);
      inj = (m_out.size() != 0) && ro && (m_out[0][63] == pol);
      inj_pkt = inj ? m_out[0] : 64'd0;

      if (en && !wr && a == 2'b00) begin
         if (m_in.size() != 0) void'(m_in.pop_front());
         else m_uf = 1;
      end else if (en && !wr && a == 2'b01) m_uf = 0;
      if (in_can_push) m_in.push_back(di);

      if (en && !wr && a == 2'b11) m_ov = 0;
      if (inj) begin
         exp_tx.push_back(inj_pkt);
         void'(m_out.pop_front());
      end
      if (en && wr && a == 2'b10) begin
         if (out_can_push) m_out.push_back(din);
         else m_ov = 1;
      end
   endtask

   task automatic idle(input logic ro, input logic pol);
      cycle(0, 0, 2'b00, 64'd0, 0, 64'd0, ro, pol);
   endtask

   // Monitor: compares every presented output against the scoreboard queues.
   always @(negedge clk) begin
      if (exp_dout.size() != 0) chk("d_out", d_out, exp_dout.pop_front());
      if (exp_ri.size() != 0)   chk("net_ri", {63'd0, net_ri}, {63'd0, exp_ri.pop_front()});
      if (reset && net_so) begin
         if (exp_tx.size() == 0) chk("net_so_spurious", 64'd1, 64'd0);
         else chk("net_do", net_do, exp_tx.pop_front());
      end
   end

   initial begin
      logic [63:0] burst[5];
      logic [63:0] p;
      burst[0] = 64'h0EDCBA9876543210; burst[1] = 64'h1111111111111111;
      burst[2] = 64'h2222222222222222; burst[3] = 64'h3333333333333333;
      burst[4] = 64'h4444444444444444;

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("reset_net_so", {63'd0, net_so}, 64'd0);
      chk("reset_net_do", net_do, 64'd0);
      chk("reset_net_ri", {63'd0, net_ri}, 64'd1);

      // empty reads: status, underflow read, flagged status, cleared status
      cycle(1, 0, 2'b01, 0, 0, 0, 0, 0);
      cycle(1, 0, 2'b00, 0, 0, 0, 0, 0);
      cycle(1, 0, 2'b01, 0, 0, 0, 0, 0);
      cycle(1, 0, 2'b01, 0, 0, 0, 0, 0);

      // router burst past full, then drain in order
      for (int i = 0; i < 5; i++) cycle(0, 0, 2'b00, 0, 1, burst[i], 0, 0);
      cycle(1, 0, 2'b01, 0, 0, 0, 0, 0);
      for (int i = 0; i < IN_D + 1; i++) cycle(1, 0, 2'b00, 0, 0, 0, 0, 0);
      cycle(1, 0, 2'b01, 0, 0, 0, 0, 0);

      // polarity-gated single injection
      cycle(1, 1, 2'b10, 64'h0BCD1234567890FF, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) idle(1, i[0] ^ 1'b1);
      cycle(1, 0, 2'b11, 0, 0, 0, 1, 0);

      // overflow with router stalled, then drain
      for (int i = 0; i < OUT_D + 1; i++) cycle(1, 1, 2'b10, {$urandom, $urandom}, 0, 0, 0, 0);
      cycle(1, 0, 2'b11, 0, 0, 0, 0, 0);
      cycle(1, 0, 2'b11, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40 && m_out.size() != 0; i++) idle(1, 1'($urandom_range(0, 1)));

      // push+pop at IN_D-1, then interleaved traffic across pointer wrap
      for (int i = 0; i < IN_D - 1; i++) cycle(0, 0, 2'b00, 0, 1, {$urandom, $urandom}, 0, 0);
      cycle(1, 0, 2'b00, 0, 1, {$urandom, $urandom}, 0, 0);
      cycle(1, 0, 2'b01, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(1, 0, 2'b00, 0, 1, {$urandom, $urandom}, 0, 0);
         if (i % 3 == 0) cycle(1, 0, 2'b00, 0, 0, 0, 0, 0);
      end

      // randomized traffic on every port
      for (int i = 0; i < 400; i++) begin
         p = {$urandom, $urandom};
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               p, 1'($urandom_range(0, 1)), {$urandom, $urandom},
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 40 && m_out.size() != 0; i++) idle(1, 1'($urandom_range(0, 1)));
      idle(0, 0);
      idle(0, 0);
      chk("tx_all_emitted", 64'(exp_tx.size()), 64'd0);

      // reset in the middle of an injection burst
      for (int i = 0; i < 3; i++) cycle(1, 1, 2'b10, {1'b0, 63'(i + 5)}, 1, {$urandom, $urandom}, 0, 0);
      idle(1, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midreset_net_so", {63'd0, net_so}, 64'd0);
      chk("midreset_net_ri", {63'd0, net_ri}, 64'd1);
      chk("midreset_net_do", net_do, 64'd0);
      exp_tx.delete();
      m_in.delete();
      m_out.delete();
      m_uf = 0;
      m_ov = 0;
      nicEn = 0; net_si = 0; net_ro = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      cycle(1, 0, 2'b01, 0, 0, 0, 0, 0);
      cycle(1, 0, 2'b11, 0, 0, 0, 0, 0);
      idle(1, 0);
      idle(1, 1);
      chk("no_tx_after_reset", 64'(exp_tx.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
